// File: rtl/pll_ratio_monitor.sv
// PLL frequency-ratio monitor in the clk_1 domain: measures clk_1 cycles between
// reference-window toggles, flags out-of-tolerance windows and stalls, drives LEDs.
module pll_ratio_monitor #(
  parameter int CNT_W   = 12,
  parameter int EXPECT  = 2048,
  parameter int TOL     = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic             clk_1,
  input  logic             rst,
  input  logic             ref_tog,
  output logic [CNT_W-1:0] meas,
  output logic             meas_valid,
  output logic             ratio_ok,
  output logic             timeout,
  output logic [7:0]       err_cnt,
  output logic [7:0]       led,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    ACQ   = 2'd0,
    MEAS  = 2'd1,
    STALE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W:0]   EXPECT_C  = (CNT_W+1)'(EXPECT);
  localparam logic [CNT_W:0]   TOL_C     = (CNT_W+1)'(TOL);

  state_t           state, state_next;
  logic             s1, s2, s3;
  logic             tog_edge;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [CNT_W-1:0] meas_next;
  logic             valid_next, ok_next, timeout_next;
  logic [7:0]       err_next, err_sat;
  logic             hb, hb_next;
  logic signed [CNT_W:0] dev;
  logic [CNT_W:0]   dev_abs;
  logic             in_tol;

  // Three-flop synchronizer; s1 may go metastable, so the edge uses s2/s3 only.
  always_ff @(posedge clk_1) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= ref_tog;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tog_edge = s2 ^ s3;

  // One extra bit keeps the signed deviation exact across the whole counter range.
  assign dev     = $signed({1'b0, cnt}) - $signed(EXPECT_C);
  assign dev_abs = dev[CNT_W] ? $unsigned(-dev) : $unsigned(dev);
  assign in_tol  = (dev_abs <= TOL_C);
  assign err_sat = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    meas_next    = meas;
    valid_next   = 1'b0;
    ok_next      = ratio_ok;
    timeout_next = timeout;
    err_next     = err_cnt;
    hb_next      = hb;
    case (state)
      ACQ: begin
        cnt_next = '0;
        if (tog_edge) begin
          state_next = MEAS;
          cnt_next   = CNT_ONE;
        end
      end
      MEAS: begin
        if (tog_edge) begin
          meas_next  = cnt;
          valid_next = 1'b1;
          ok_next    = in_tol;
          hb_next    = ~hb;
          cnt_next   = CNT_ONE;
          if (!in_tol) err_next = err_sat;
        end else begin
          cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          if (cnt == TIMEOUT_C) begin
            state_next   = STALE;
            timeout_next = 1'b1;
            ok_next      = 1'b0;
            err_next     = err_sat;
          end
        end
      end
      STALE: begin
        // The window ending on this edge started before the stall, so it is dropped.
        if (tog_edge) begin
          state_next   = MEAS;
          cnt_next     = CNT_ONE;
          timeout_next = 1'b0;
        end
      end
      default: begin
        state_next = ACQ;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_1) begin
    if (!rst) begin
      state      <= ACQ;
      cnt        <= '0;
      meas       <= '0;
      meas_valid <= 1'b0;
      ratio_ok   <= 1'b0;
      timeout    <= 1'b0;
      err_cnt    <= 8'd0;
      hb         <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      meas       <= meas_next;
      meas_valid <= valid_next;
      ratio_ok   <= ok_next;
      timeout    <= timeout_next;
      err_cnt    <= err_next;
      hb         <= hb_next;
    end
  end

  assign led       = {err_cnt[3:0], (state == ACQ), hb, timeout, ratio_ok};
  assign fsm_state = state;

endmodule
